// File: rtl/interrupt_ctrl_pkg.sv
// rtl/interrupt_ctrl_pkg.sv - shared CSR addresses, cause codes, mstatus/mie bit positions and FSM encodings
package interrupt_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MSTATUS,
    W_MCAUSE,
    TRAP_JUMP,
    MRET_MSTATUS,
    MRET_JUMP
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_ECALL,
    EVT_MRET,
    EVT_IRQ
  } event_e;

endpackage

// File: rtl/int_prio.sv
// rtl/int_prio.sv - combinational event priority selection and cause encoding
module int_prio
  import interrupt_ctrl_pkg::*;
(
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        global_mie_i,
  input  logic        meie_i,
  input  logic        msie_i,
  input  logic        mtie_i,
  output event_e      evt_o,
  output logic [31:0] cause_o
);

  // ecall beats mret beats interrupts; among interrupts ext > sw > timer
  always_comb begin
    evt_o   = EVT_NONE;
    cause_o = '0;
    if (ecall_i) begin
      evt_o   = EVT_ECALL;
      cause_o = CAUSE_ECALL;
    end else if (mret_i) begin
      evt_o = EVT_MRET;
    end else if (global_mie_i) begin
      if (meie_i && irq_ext_i) begin
        evt_o   = EVT_IRQ;
        cause_o = CAUSE_EXT;
      end else if (msie_i && irq_sw_i) begin
        evt_o   = EVT_IRQ;
        cause_o = CAUSE_SW;
      end else if (mtie_i && irq_timer_i) begin
        evt_o   = EVT_IRQ;
        cause_o = CAUSE_TIMER;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// rtl/interrupt_ctrl.sv - trap/mret sequencer with CSR write port; INT_VECTORED_EN enables vectored mtvec
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      irq_ext_i,
  input  logic                      irq_sw_i,
  input  logic                      irq_timer_i,
  input  logic                      ecall_i,
  input  logic                      mret_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic                      jump_flag_i,
  input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
  input  logic [ADDR_WIDTH-1:0]     mtvec_i,
  input  logic [ADDR_WIDTH-1:0]     mepc_i,
  input  logic [DATA_WIDTH-1:0]     mstatus_i,
  input  logic [DATA_WIDTH-1:0]     mie_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      hold_flag_o,
  output logic                      int_assert_o,
  output logic [ADDR_WIDTH-1:0]     int_addr_o
);

  state_e                state_q;
  event_e                evt;
  logic [31:0]           cause_sel;
  logic [31:0]           cause_q;
  logic [ADDR_WIDTH-1:0] pc_sel;
  logic [ADDR_WIDTH-1:0] trap_base;
  logic [ADDR_WIDTH-1:0] trap_target;
  logic                  unused_inputs;

  int_prio u_int_prio (
    .ecall_i      (ecall_i),
    .mret_i       (mret_i),
    .irq_ext_i    (irq_ext_i),
    .irq_sw_i     (irq_sw_i),
    .irq_timer_i  (irq_timer_i),
    .global_mie_i (mstatus_i[MSTATUS_MIE]),
    .meie_i       (mie_i[MIE_MEIE]),
    .msie_i       (mie_i[MIE_MSIE]),
    .mtie_i       (mie_i[MIE_MTIE]),
    .evt_o        (evt),
    .cause_o      (cause_sel)
  );

  // trap entry: stack MIE into MPIE, disable MIE, return to M-mode
  function automatic logic [DATA_WIDTH-1:0] trap_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_LO +: 2] = 2'b11;
    return r;
  endfunction

  // mret: restore MIE from MPIE, set MPIE, keep MPP at M-mode
  function automatic logic [DATA_WIDTH-1:0] mret_mstatus(input logic [DATA_WIDTH-1:0] ms);
    logic [DATA_WIDTH-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_LO +: 2] = 2'b11;
    return r;
  endfunction

  assign pc_sel    = jump_flag_i ? jump_addr_i : inst_addr_i;
  assign trap_base = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};

`ifdef INT_VECTORED_EN
  assign trap_target = (mtvec_i[1:0] == 2'b01 && cause_q[31])
                     ? trap_base + ADDR_WIDTH'({cause_q[4:0], 2'b00})
                     : trap_base;
`else
  assign trap_target = trap_base;
`endif

  // only the enable bits of mie and the base bits of mtvec are consumed everywhere
  assign unused_inputs = ^{mie_i, mtvec_i[1:0]};

  // stall while accepting an event and for the whole sequence; reset forces it low
  assign hold_flag_o = rst_ni && ((state_q != IDLE) || (evt != EVT_NONE));

  // sequencer with registered CSR write port and redirect outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      case (state_q)
        IDLE: begin
          if (evt == EVT_ECALL || evt == EVT_IRQ) begin
            state_q     <= W_MEPC;
            cause_q     <= cause_sel;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MEPC);
            csr_wdata_o <= DATA_WIDTH'(pc_sel);
          end else if (evt == EVT_MRET) begin
            state_q     <= MRET_MSTATUS;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
            csr_wdata_o <= mret_mstatus(mstatus_i);
          end
        end
        W_MEPC: begin
          state_q     <= W_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
          csr_wdata_o <= trap_mstatus(mstatus_i);
        end
        W_MSTATUS: begin
          state_q     <= W_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MCAUSE);
          csr_wdata_o <= DATA_WIDTH'(cause_q);
        end
        W_MCAUSE: begin
          state_q      <= TRAP_JUMP;
          int_assert_o <= 1'b1;
          int_addr_o   <= trap_target;
        end
        MRET_MSTATUS: begin
          state_q      <= MRET_JUMP;
          int_assert_o <= 1'b1;
          int_addr_o   <= mepc_i;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb/tb_interrupt_ctrl.sv - self-checking bench for interrupt_ctrl with directed and random events
module tb_interrupt_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        irq_ext_i, irq_sw_i, irq_timer_i;
  logic        ecall_i, mret_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i, mie_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int errors = 0;

  interrupt_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_ext_i    (irq_ext_i),
    .irq_sw_i     (irq_sw_i),
    .irq_timer_i  (irq_timer_i),
    .ecall_i      (ecall_i),
    .mret_i       (mret_i),
    .inst_addr_i  (inst_addr_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .mstatus_i    (mstatus_i),
    .mie_i        (mie_i),
    .csr_we_o     (csr_we_o),
    .csr_waddr_o  (csr_waddr_o),
    .csr_wdata_o  (csr_wdata_o),
    .hold_flag_o  (hold_flag_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic hold, input logic we,
                               input logic [31:0] waddr, input logic [31:0] wdata,
                               input logic ia, input logic [31:0] iaddr);
    check({tag, ".hold"},  {31'd0, hold_flag_o},  {31'd0, hold});
    check({tag, ".we"},    {31'd0, csr_we_o},     {31'd0, we});
    check({tag, ".waddr"}, {20'd0, csr_waddr_o},  waddr);
    check({tag, ".wdata"}, csr_wdata_o,           wdata);
    check({tag, ".ia"},    {31'd0, int_assert_o}, {31'd0, ia});
    check({tag, ".iaddr"}, int_addr_o,            iaddr);
  endtask

  task automatic clear_events();
    ecall_i = 0; mret_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0;
  endtask

  // Applies one IDLE-cycle stimulus (called at #1 after a rising edge with the DUT idle),
  // then walks the expected CSR-write / redirect sequence derived from the trap rules.
  task automatic do_txn(input string tag, input logic ec, input logic mr,
                        input logic ie, input logic is, input logic it,
                        input logic [31:0] ms, input logic [31:0] me, input logic [31:0] pc,
                        input logic jf, input logic [31:0] ja,
                        input logic [31:0] mtv, input logic [31:0] mep);
    int          kind;   // 0 none, 1 trap, 2 mret
    logic [31:0] cause, saved_pc, base, target, mie_bit, mpie_bit;
    logic [1:0]  mode;
    logic [31:0] e_addr[4];
    logic [31:0] e_data[4];
    logic        e_we[4];
    logic        e_ia[4];
    logic [31:0] e_iaddr[4];
    logic [31:0] irq_cause[3];
    logic        irq_on[3];
    int          nsteps;

    ecall_i = ec; mret_i = mr; irq_ext_i = ie; irq_sw_i = is; irq_timer_i = it;
    mstatus_i = ms; mie_i = me; inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = ja;
    mtvec_i = mtv; mepc_i = mep;

    irq_cause[0] = 32'h8000000B; irq_on[0] = ie && ((me >> 11) & 1) != 0;
    irq_cause[1] = 32'h80000003; irq_on[1] = is && ((me >> 3) & 1) != 0;
    irq_cause[2] = 32'h80000007; irq_on[2] = it && ((me >> 7) & 1) != 0;
    kind  = 0;
    cause = 0;
    if (ec) begin
      kind = 1; cause = 11;
    end else if (mr) begin
      kind = 2;
    end else if (((ms >> 3) & 1) != 0) begin
      for (int i = 2; i >= 0; i--) begin
        if (irq_on[i]) begin kind = 1; cause = irq_cause[i]; end
      end
    end
    saved_pc = jf ? ja : pc;
    base     = mtv & ~32'h3;
    target   = base;
    mode     = mtv[1:0];
`ifdef INT_VECTORED_EN
    if (mode == 2'b01 && cause >= 32'h80000000) target = base + 4 * (cause & 32'h1F);
`else
    if (mode == 2'b01) target = base;
`endif
    mie_bit  = (ms >> 3) & 1;
    mpie_bit = (ms >> 7) & 1;

    nsteps = 0;
    if (kind == 1) begin
      nsteps = 4;
      e_we[0] = 1; e_addr[0] = 32'h341; e_data[0] = saved_pc; e_ia[0] = 0; e_iaddr[0] = 0;
      e_we[1] = 1; e_addr[1] = 32'h300;
      e_data[1] = (ms & ~32'h1888) | (mie_bit << 7) | (32'd3 << 11);
      e_ia[1] = 0; e_iaddr[1] = 0;
      e_we[2] = 1; e_addr[2] = 32'h342; e_data[2] = cause; e_ia[2] = 0; e_iaddr[2] = 0;
      e_we[3] = 0; e_addr[3] = 0; e_data[3] = 0; e_ia[3] = 1; e_iaddr[3] = target;
    end else if (kind == 2) begin
      nsteps = 2;
      e_we[0] = 1; e_addr[0] = 32'h300;
      e_data[0] = (ms & ~32'h1888) | (mpie_bit << 3) | (32'd1 << 7) | (32'd3 << 11);
      e_ia[0] = 0; e_iaddr[0] = 0;
      e_we[1] = 0; e_addr[1] = 0; e_data[1] = 0; e_ia[1] = 1; e_iaddr[1] = mep;
    end

    @(negedge clk_i);
    check_outputs({tag, ".accept"}, kind != 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < nsteps; s++) begin
      @(posedge clk_i); #1;
      if (s == nsteps - 1) clear_events();
      else begin
        ecall_i = 1'($urandom); mret_i = 1'($urandom);
        irq_ext_i = 1'($urandom); irq_sw_i = 1'($urandom); irq_timer_i = 1'($urandom);
      end
      @(negedge clk_i);
      check_outputs($sformatf("%s.step%0d", tag, s), 1, e_we[s], e_addr[s], e_data[s],
                    e_ia[s], e_iaddr[s]);
    end
    @(posedge clk_i); #1;
    clear_events();
  endtask

  initial begin
    rst_ni = 0;
    clear_events();
    inst_addr_i = 0; jump_flag_i = 0; jump_addr_i = 0;
    mtvec_i = 0; mepc_i = 0; mstatus_i = 0; mie_i = 0;

    #12;
    check_outputs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(posedge clk_i); #1;

    do_txn("timer",     0, 0, 0, 0, 1, 32'h8,    32'h80,  32'h100, 0, 32'h0,  32'h200, 32'h0);
    do_txn("ecall",     1, 0, 1, 0, 0, 32'h8,    32'h800, 32'h80,  1, 32'h40, 32'h200, 32'h0);
    do_txn("mret",      0, 1, 0, 0, 0, 32'h1880, 32'h0,   32'h0,   0, 32'h0,  32'h200, 32'h104);
    do_txn("mie_off",   0, 0, 1, 1, 1, 32'h0,    32'h888, 32'h300, 0, 32'h0,  32'h200, 32'h0);
    do_txn("all_irq",   0, 0, 1, 1, 1, 32'h8,    32'h888, 32'h300, 0, 32'h0,  32'h200, 32'h0);
    do_txn("sw_irq",    0, 0, 0, 1, 1, 32'h8,    32'h888, 32'h310, 0, 32'h0,  32'h200, 32'h0);
    do_txn("ecall_mret",1, 1, 0, 0, 0, 32'h0,    32'h0,   32'h500, 0, 32'h0,  32'h400, 32'h99);
    do_txn("vec_timer", 0, 0, 0, 0, 1, 32'h8,    32'h80,  32'h100, 0, 32'h0,  32'h201, 32'h0);

    // reset in the middle of a trap, while the mstatus write is on the port
    irq_timer_i = 1; mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h200;
    @(posedge clk_i); #1;
    clear_events();
    @(posedge clk_i); #1;
    check("midrst.pre_we",    {31'd0, csr_we_o}, 32'd1);
    check("midrst.pre_waddr", {20'd0, csr_waddr_o}, 32'h300);
    irq_timer_i = 1;
    rst_ni = 0;
    #1;
    check_outputs("midrst.async", 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    check_outputs("midrst.held", 0, 0, 0, 0, 0, 0);
    irq_timer_i = 0;
    rst_ni = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check_outputs($sformatf("midrst.after%0d", c), 0, 0, 0, 0, 0, 0);
    end
    @(posedge clk_i); #1;

    for (int n = 0; n < 150; n++) begin
      do_txn($sformatf("rnd%0d", n),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, $urandom & ~32'h3, 1'($urandom), $urandom & ~32'h3,
             $urandom, $urandom & ~32'h3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
